instr_memaccess: RTL and testbench

Memory-access stage directly downstream of the execute stage. Takes the ALU result as the effective address and the rs2 value as store data, runs a request/grant/response transaction against the data memory, and aligns the data. It produces sign- or zero-extended load data for writeback and stalls upstream stages while a transaction is in flight.

---
 rtl/mem_pkg.sv | 34 +++
 rtl/load_align.sv | 35 +++
 rtl/instr_memaccess.sv | 167 ++++++++++++++++
 tb/tb_instr_memaccess.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 codes, FSM states, legality/alignment helpers.
// Latency: none (definitions only).
// Backpressure: n/a.
package mem_pkg;

   // RV32I load/store funct3 encodings
   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} memacc_state_t;

   // funct3[1:0] carries the access size for both loads and stores
   function automatic logic aligned(input logic [2:0] funct3, input logic [1:0] offset);
      case (funct3[1:0])
         2'b01:   return ~offset[0];
         2'b10:   return (offset == 2'b00);
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic legal(input logic is_store, input logic [2:0] funct3);
      if (is_store)
         return (funct3 == SB) || (funct3 == SH) || (funct3 == SW);
      return (funct3 == LB) || (funct3 == LH) || (funct3 == LW) ||
             (funct3 == LBU) || (funct3 == LHU);
   endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword of a read word and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none.
// Ports: rdata (read word), offset (byte address bits), funct3 (load type) -> ext_data.
module load_align
   import mem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] ext_data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (offset)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         LB:      ext_data = {{24{byte_sel[7]}}, byte_sel};
         LH:      ext_data = {{16{half_sel[15]}}, half_sel};
         LBU:     ext_data = {24'h0, byte_sel};
         LHU:     ext_data = {16'h0, half_sel};
         default: ext_data = rdata;
      endcase
   end

endmodule

// File: rtl/instr_memaccess.sv
// Memory-access stage: issues req/gnt/rvalid transactions to data memory, aligns stores and extends loads.
// Latency: store 2 cycles start->mem_done, load >=3 cycles; timeout after TIMEOUT+1 cycles in REQ/WAIT.
// Backpressure: stall holds upstream while a legal access is accepted or in REQ/WAIT; dmem_req held until gnt.
// Ports: upstream valid/mem_read/mem_write/funct3/addr/store_data; dmem_* bus; stall, mem_done,
//        load_data, misalign_err, bus_err to pipeline.
module instr_memaccess
   import mem_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        valid,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_gnt,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        mem_done,
   output logic [31:0] load_data,
   output logic        misalign_err,
   output logic        bus_err
);

   localparam logic [9:0] TMO = TIMEOUT[9:0];

   memacc_state_t state, state_nxt;
   logic [9:0]    cnt;
   logic          bus_err_q;
   logic [31:0]   load_q;
   logic [2:0]    f3_q;
   logic [1:0]    off_q;
   logic [31:0]   ext_data;
   logic [3:0]    be_nxt;
   logic [31:0]   wdata_nxt;

   // a simultaneous read and write is treated as a load
   wire is_store = mem_write & ~mem_read;
   wire start    = valid & (mem_read | mem_write);
   wire ok       = legal(is_store, funct3) & aligned(funct3, addr[1:0]);
   wire timeout  = (cnt == TMO);

   load_align u_load_align (
      .rdata    (dmem_rdata),
      .offset   (off_q),
      .funct3   (f3_q),
      .ext_data (ext_data)
   );

   // lane placement of store data
   always_comb begin
      case (funct3[1:0])
         2'b00: begin
            be_nxt    = 4'b0001 << addr[1:0];
            wdata_nxt = {4{store_data[7:0]}};
         end
         2'b01: begin
            be_nxt    = 4'b0011 << {addr[1], 1'b0};
            wdata_nxt = {2{store_data[15:0]}};
         end
         default: begin
            be_nxt    = 4'b1111;
            wdata_nxt = store_data;
         end
      endcase
   end

   always_comb begin
      state_nxt    = state;
      stall        = 1'b0;
      misalign_err = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (ok) begin
                  state_nxt = REQ;
                  stall     = 1'b1;
               end else begin
                  misalign_err = 1'b1;
               end
            end
         end
         REQ: begin
            stall = 1'b1;
            if (timeout)
               state_nxt = RESP;
            else if (dmem_gnt)
               state_nxt = dmem_we ? RESP : WAIT;
         end
         WAIT: begin
            stall = 1'b1;
            if (timeout || dmem_rvalid)
               state_nxt = RESP;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         bus_err_q  <= 1'b0;
         load_q     <= '0;
         f3_q       <= '0;
         off_q      <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_be    <= '0;
         dmem_wdata <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (start && ok) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= is_store;
                  dmem_addr  <= {addr[31:2], 2'b00};
                  dmem_be    <= be_nxt;
                  dmem_wdata <= is_store ? wdata_nxt : 32'h0;
                  f3_q       <= funct3;
                  off_q      <= addr[1:0];
                  cnt        <= '0;
                  bus_err_q  <= 1'b0;
                  load_q     <= '0;
               end
            end
            REQ: begin
               cnt <= cnt + 10'd1;
               // timeout wins over a grant arriving in the same cycle
               if (timeout) begin
                  dmem_req  <= 1'b0;
                  bus_err_q <= 1'b1;
                  load_q    <= '0;
               end else if (dmem_gnt) begin
                  dmem_req <= 1'b0;
               end
            end
            WAIT: begin
               cnt <= cnt + 10'd1;
               if (timeout) begin
                  bus_err_q <= 1'b1;
                  load_q    <= '0;
               end else if (dmem_rvalid) begin
                  load_q <= ext_data;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_done  = (state == RESP);
   assign bus_err   = mem_done & bus_err_q;
   assign load_data = mem_done ? load_q : 32'h0;

endmodule

// File: tb/tb_instr_memaccess.sv
// Directed bench for instr_memaccess: stores, loads, misalignment, timeout, reset mid-load, back-to-back.
// Latency: n/a.
// Backpressure: n/a.
module tb_instr_memaccess;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0, t_valid = 1'b0;
   logic        mem_read = 1'b0, mem_write = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = '0, store_data = '0;
   logic        dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
   logic [31:0] dmem_rdata = '0;

   logic        dmem_req, dmem_we, stall, mem_done, misalign_err, bus_err;
   logic [31:0] dmem_addr, dmem_wdata, load_data;
   logic [3:0]  dmem_be;

   logic        t_req, t_we, t_stall, t_done, t_mis, t_bus_err;
   logic [31:0] t_addr, t_wdata, t_load_data;
   logic [3:0]  t_be;

   int n_chk = 0;
   int n_err = 0;
   int n_done = 0;
   int d0;

   always #5 clk = ~clk;

   instr_memaccess dut (
      .clk(clk), .rst_n(rst_n), .valid(valid), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .store_data(store_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
      .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .stall(stall), .mem_done(mem_done), .load_data(load_data),
      .misalign_err(misalign_err), .bus_err(bus_err)
   );

   // short-timeout instance; its memory never grants
   instr_memaccess #(.TIMEOUT(4)) dut_to (
      .clk(clk), .rst_n(rst_n), .valid(t_valid), .mem_read(mem_read), .mem_write(mem_write),
      .funct3(funct3), .addr(addr), .store_data(store_data),
      .dmem_req(t_req), .dmem_we(t_we), .dmem_addr(t_addr), .dmem_be(t_be),
      .dmem_wdata(t_wdata), .dmem_gnt(1'b0), .dmem_rvalid(1'b0),
      .dmem_rdata(32'h0), .stall(t_stall), .mem_done(t_done), .load_data(t_load_data),
      .misalign_err(t_mis), .bus_err(t_bus_err)
   );

   always @(negedge clk) if (mem_done) n_done++;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] sd, input logic [3:0] exp_be, input logic [31:0] exp_wd);
      tick();
      valid = 1'b1; mem_write = 1'b1; mem_read = 1'b0; funct3 = f3; addr = a; store_data = sd;
      #1 check({tag, " c0 stall"}, stall, 1);
      check({tag, " c0 req"}, dmem_req, 0);
      tick();
      valid = 1'b0; mem_write = 1'b0; dmem_gnt = 1'b1;
      #1 check({tag, " req"}, dmem_req, 1);
      check({tag, " we"}, dmem_we, 1);
      check({tag, " addr"}, dmem_addr, {a[31:2], 2'b00});
      check({tag, " be"}, dmem_be, exp_be);
      check({tag, " wdata"}, dmem_wdata, exp_wd);
      check({tag, " c1 stall"}, stall, 1);
      tick();
      dmem_gnt = 1'b0;
      #1 check({tag, " done"}, mem_done, 1);
      check({tag, " done stall"}, stall, 0);
      check({tag, " bus_err"}, bus_err, 0);
      check({tag, " req drop"}, dmem_req, 0);
      tick();
      #1 check({tag, " done pulse"}, mem_done, 0);
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd, input int waits, input logic [31:0] expv);
      tick();
      valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = f3; addr = a;
      #1 check({tag, " c0 stall"}, stall, 1);
      tick();
      valid = 1'b0; mem_read = 1'b0; dmem_gnt = (waits == 0);
      #1 check({tag, " req"}, dmem_req, 1);
      check({tag, " addr"}, dmem_addr, {a[31:2], 2'b00});
      check({tag, " we"}, dmem_we, 0);
      for (int i = 0; i < waits; i++) begin
         tick();
         dmem_gnt = (i == waits - 1);
         #1 check({tag, " req held"}, dmem_req, 1);
      end
      tick();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rd;
      #1 check({tag, " wait req"}, dmem_req, 0);
      check({tag, " wait stall"}, stall, 1);
      tick();
      dmem_rvalid = 1'b0;
      #1 check({tag, " done"}, mem_done, 1);
      check({tag, " data"}, load_data, expv);
      check({tag, " bus_err"}, bus_err, 0);
      check({tag, " done stall"}, stall, 0);
      tick();
      #1 check({tag, " data cleared"}, load_data, 0);
   endtask

   initial begin
      #12 rst_n = 1'b1;
      #1;
      check("rst req", dmem_req, 0);
      check("rst be", dmem_be, 0);
      check("rst addr", dmem_addr, 0);
      check("rst stall", stall, 0);
      check("rst done", mem_done, 0);
      check("rst load_data", load_data, 0);
      check("rst bus_err", bus_err, 0);

      do_store("sb", 3'b000, 32'h0000_1003, 32'h0000_00A5, 4'b1000, 32'hA5A5_A5A5);
      do_store("sh", 3'b001, 32'h0000_1002, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF);
      do_load("lh", 3'b001, 32'h0000_2002, 32'h8001_1234, 3, 32'hFFFF_8001);
      do_load("lhu", 3'b101, 32'h0000_2002, 32'h8001_1234, 3, 32'h0000_8001);
      do_load("lb", 3'b000, 32'h0000_7003, 32'h8000_0000, 0, 32'hFFFF_FF80);
      do_load("lw", 3'b010, 32'h0000_7000, 32'h89AB_CDEF, 1, 32'h89AB_CDEF);

      // misaligned word load
      d0 = n_done;
      tick();
      valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_3001;
      #1 check("mis lw err", misalign_err, 1);
      check("mis lw stall", stall, 0);
      tick();
      #1 check("mis lw req", dmem_req, 0);
      check("mis lw err held", misalign_err, 1);
      // illegal store funct3, then a misaligned halfword load
      valid = 1'b1; mem_read = 1'b0; mem_write = 1'b1; funct3 = 3'b011; addr = 32'h0000_3000;
      #1 check("ill st err", misalign_err, 1);
      check("ill st stall", stall, 0);
      mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b001; addr = 32'h0000_3001;
      #1 check("mis lh err", misalign_err, 1);
      valid = 1'b0; mem_read = 1'b0;
      #1 check("mis idle err", misalign_err, 0);
      tick();
      #1 check("mis req none", dmem_req, 0);
      check("mis no done", n_done - d0, 0);

      // timeout on the TIMEOUT=4 instance
      tick();
      t_valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_4000;
      #1 check("to c0 stall", t_stall, 1);
      tick();
      t_valid = 1'b0; mem_read = 1'b0;
      #1 check("to req t0", t_req, 1);
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("to req held", t_req, 1);
         check("to not done", t_done, 0);
      end
      tick();
      check("to done", t_done, 1);
      check("to bus_err", t_bus_err, 1);
      check("to load_data", t_load_data, 0);
      check("to req drop", t_req, 0);
      check("to stall", t_stall, 0);
      tick();
      check("to done pulse", t_done, 0);

      // reset while waiting for read data
      tick();
      valid = 1'b1; mem_read = 1'b1; funct3 = 3'b010; addr = 32'h0000_5004;
      tick();
      valid = 1'b0; mem_read = 1'b0; dmem_gnt = 1'b1;
      tick();
      dmem_gnt = 1'b0;
      #1 check("rml wait stall", stall, 1);
      d0 = n_done;
      rst_n = 1'b0;
      #1 check("rml req", dmem_req, 0);
      check("rml addr", dmem_addr, 0);
      check("rml be", dmem_be, 0);
      check("rml wdata", dmem_wdata, 0);
      check("rml we", dmem_we, 0);
      check("rml stall", stall, 0);
      check("rml done", mem_done, 0);
      check("rml load_data", load_data, 0);
      tick();
      rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hCAFE_F00D;
      tick();
      dmem_rvalid = 1'b0;
      #1 check("rml post done", mem_done, 0);
      check("rml post stall", stall, 0);
      tick();
      check("rml no done", n_done - d0, 0);

      // store then load offered during RESP
      d0 = n_done;
      tick();
      valid = 1'b1; mem_write = 1'b1; mem_read = 1'b0; funct3 = 3'b010;
      addr = 32'h0000_6000; store_data = 32'hDEAD_BEEF;
      #1 check("b2b st stall", stall, 1);
      tick();
      valid = 1'b0; mem_write = 1'b0; dmem_gnt = 1'b1;
      #1 check("b2b st wdata", dmem_wdata, 32'hDEAD_BEEF);
      check("b2b st be", dmem_be, 4'b1111);
      tick();
      dmem_gnt = 1'b0; valid = 1'b1; mem_read = 1'b1; funct3 = 3'b100; addr = 32'h0000_6001;
      #1 check("b2b resp done", mem_done, 1);
      check("b2b resp stall", stall, 0);
      tick();
      #1 check("b2b idle done", mem_done, 0);
      check("b2b idle stall", stall, 1);
      tick();
      valid = 1'b0; mem_read = 1'b0; dmem_gnt = 1'b1;
      #1 check("b2b ld req", dmem_req, 1);
      check("b2b ld addr", dmem_addr, 32'h0000_6000);
      check("b2b ld we", dmem_we, 0);
      tick();
      dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_80FF;
      tick();
      dmem_rvalid = 1'b0;
      #1 check("b2b ld done", mem_done, 1);
      check("b2b ld data", load_data, 32'h0000_0080);
      tick();
      check("b2b done count", n_done - d0, 2);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
